// File: rtl/garbage_injector_pkg.sv
// Shared constants and state encoding for the garbage injector.
package garbage_injector_pkg;

    // Default geometry and limits
    localparam int BOARD_W     = 10;
    localparam int CNT_W       = 5;
    localparam int MAX_PENDING = 20;
    localparam int MAX_BURST   = 4;
    localparam int RND_W       = 5;

    // Injector FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/garbage_injector_hole_select.sv
// Maps a PRNG sample to a hole column, avoiding a repeat of the previous burst's hole.
module garbage_injector_hole_select
    import garbage_injector_pkg::*;
#(
    parameter int BOARD_W_P = BOARD_W,
    parameter int RND_W_P   = RND_W,
    parameter int HOLE_W_P  = $clog2(BOARD_W_P)
) (
    input  logic [RND_W_P-1:0]  rnd,
    input  logic [HOLE_W_P-1:0] last_hole,
    output logic [HOLE_W_P-1:0] hole
);

    logic [HOLE_W_P-1:0] base_s;

    // Reduce rnd modulo the board width, then step one column on if it repeats
    always_comb begin
        base_s = HOLE_W_P'(rnd % RND_W_P'(BOARD_W_P));
        hole   = base_s;
        if (base_s == last_hole) begin
            if (base_s == HOLE_W_P'(BOARD_W_P - 1)) begin
                hole = {HOLE_W_P{1'b0}};
            end else begin
                hole = base_s + {{(HOLE_W_P-1){1'b0}}, 1'b1};
            end
        end else begin
            hole = base_s;
        end
    end

endmodule

// File: rtl/garbage_injector.sv
// Garbage injector: accumulates attack lines, offsets them with clears, and
// pushes one-hole garbage rows into the board in bursts at safe points.
module garbage_injector
    import garbage_injector_pkg::*;
#(
    parameter int BOARD_W_P     = BOARD_W,
    parameter int CNT_W_P       = CNT_W,
    parameter int MAX_PENDING_P = MAX_PENDING,
    parameter int MAX_BURST_P   = MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RND_W-1:0]     rnd,
    input  logic                 atk_valid,
    input  logic [CNT_W_P-1:0]   atk_lines,
    input  logic                 cancel_valid,
    input  logic [CNT_W_P-1:0]   cancel_lines,
    input  logic                 inject_en,
    output logic                 row_valid,
    output logic [BOARD_W_P-1:0] row_data,
    input  logic                 row_ready,
    output logic [CNT_W_P-1:0]   pending,
    output logic                 busy
);

    localparam int HOLE_W = $clog2(BOARD_W_P);
    localparam int BL_W   = $clog2(MAX_BURST_P + 1);
    localparam int W1     = CNT_W_P + 1;
    localparam logic [W1-1:0] MAX_PEND_W = W1'(MAX_PENDING_P);

    state_t               state_r;
    logic                 row_valid_r;
    logic [BOARD_W_P-1:0] row_data_r;
    logic                 busy_r;
    logic [BL_W-1:0]      burst_left_r;
    logic [HOLE_W-1:0]    last_hole_r;
    logic [CNT_W_P-1:0]   pending_r;

    logic                 accept_s;
    logic [HOLE_W-1:0]    hole_s;
    logic [BOARD_W_P-1:0] mask_s;
    logic [BL_W-1:0]      take_s;
    logic [W1-1:0]        add_s;
    logic [W1-1:0]        cancel_s;
    logic [W1-1:0]        sum_s;
    logic [W1-1:0]        diff_s;
    logic [W1-1:0]        floor_s;
    logic [W1-1:0]        kept_s;
    logic [W1-1:0]        popped_s;
    logic [CNT_W_P-1:0]   pending_next_s;

    assign accept_s  = row_valid_r & row_ready;
    assign row_valid = row_valid_r;
    assign row_data  = row_data_r;
    assign pending   = pending_r;
    assign busy      = busy_r;

    garbage_injector_hole_select #(
        .BOARD_W_P (BOARD_W_P),
        .RND_W_P   (RND_W),
        .HOLE_W_P  (HOLE_W)
    ) u_hole_select (
        .rnd       (rnd),
        .last_hole (last_hole_r),
        .hole      (hole_s)
    );

    // Full row with a single zero at the chosen hole column
    always_comb begin
        mask_s = {BOARD_W_P{1'b1}};
        for (int i = 0; i < BOARD_W_P; i++) begin
            if (hole_s == HOLE_W'(i)) begin
                mask_s[i] = 1'b0;
            end else begin
                mask_s[i] = 1'b1;
            end
        end
    end

    // Burst length: whatever is pending, capped at the per-opportunity maximum
    always_comb begin
        take_s = {BL_W{1'b0}};
        if (pending_r >= CNT_W_P'(MAX_BURST_P)) begin
            take_s = BL_W'(MAX_BURST_P);
        end else begin
            take_s = pending_r[BL_W-1:0];
        end
    end

    // Next pending count: add, cancel down to the committed-burst floor, pop, saturate
    always_comb begin
        add_s    = {W1{1'b0}};
        cancel_s = {W1{1'b0}};
        if (atk_valid) begin
            add_s = {1'b0, atk_lines};
        end else begin
            add_s = {W1{1'b0}};
        end
        if (cancel_valid) begin
            cancel_s = {1'b0, cancel_lines};
        end else begin
            cancel_s = {W1{1'b0}};
        end
        sum_s = {1'b0, pending_r} + add_s;
        if (sum_s > cancel_s) begin
            diff_s = sum_s - cancel_s;
        end else begin
            diff_s = {W1{1'b0}};
        end
        floor_s = {{(W1-BL_W){1'b0}}, burst_left_r};
        if (diff_s < floor_s) begin
            kept_s = floor_s;
        end else begin
            kept_s = diff_s;
        end
        popped_s = kept_s - {{(W1-1){1'b0}}, accept_s};
        if (popped_s > MAX_PEND_W) begin
            pending_next_s = MAX_PEND_W[CNT_W_P-1:0];
        end else begin
            pending_next_s = popped_s[CNT_W_P-1:0];
        end
    end

    // Pending-line counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r <= {CNT_W_P{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Injector FSM with registered row, busy and burst bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            row_valid_r  <= 1'b0;
            row_data_r   <= {BOARD_W_P{1'b0}};
            busy_r       <= 1'b0;
            burst_left_r <= {BL_W{1'b0}};
            last_hole_r  <= HOLE_W'(BOARD_W_P - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (inject_en && (pending_r != {CNT_W_P{1'b0}})) begin
                        state_r <= PICK;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                PICK: begin
                    last_hole_r <= hole_s;
                    row_data_r  <= mask_s;
                    // A same-cycle cancel may have emptied pending; then nothing to send
                    if (take_s != {BL_W{1'b0}}) begin
                        burst_left_r <= take_s;
                        row_valid_r  <= 1'b1;
                        state_r      <= EMIT;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                    end
                end
                EMIT: begin
                    if (accept_s) begin
                        burst_left_r <= burst_left_r - {{(BL_W-1){1'b0}}, 1'b1};
                        if (burst_left_r == {{(BL_W-1){1'b0}}, 1'b1}) begin
                            row_valid_r <= 1'b0;
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                        end else begin
                            row_valid_r <= 1'b1;
                        end
                    end else begin
                        row_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    row_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    burst_left_r <= {BL_W{1'b0}};
                end
            endcase
        end
    end

endmodule
